wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters: the in-order pipeline writeback (MEM/WB) and a long-latency side unit such as SAD or multiply.
- Pipeline writes always win. Side-unit results are buffered in a small FIFO and drained into idle writeback slots.
- Exports a pending-register scoreboard so the ID hazard logic can stall readers of queued results.
- Forces a pipeline bubble when a queued result starves.

---
 rtl/wb_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. Pipeline writeback has priority, and side-unit results
// queue in a small FIFO that drains into idle slots. A scoreboard and a starvation bubble protect ID.
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MEM_WB_RegWrite,
    input  logic [4:0]  MEM_WB_WriteRegister,
    input  logic [31:0] MEM_WB_WriteData,
    input  logic        side_valid,
    output logic        side_ready,
    input  logic [4:0]  side_reg,
    input  logic [31:0] side_data,
    input  logic [4:0]  query_rs,
    input  logic [4:0]  query_rt,
    output logic        WB_RegWrite,
    output logic [4:0]  WB_WriteRegister,
    output logic [31:0] WB_WriteData,
    output logic [31:0] pending_mask,
    output logic        hazard_rs,
    output logic        hazard_rt,
    output logic        stall_req,
    output logic        collision_err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_BUBBLE = 2'd2
    } state_t;

    logic [4:0]    reg_mem  [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    starve_q;
    state_t        state_q;
    logic          collision_q;

    logic pipe_active;
    logic fifo_empty;
    logic enq;
    logic deq;
    logic head_blocked;

    assign pipe_active  = MEM_WB_RegWrite && (MEM_WB_WriteRegister != 5'd0);
    assign fifo_empty   = (count_q == '0);
    assign side_ready   = (count_q != CW'(DEPTH));
    // Register-0 results are acknowledged but never stored.
    assign enq          = side_valid && side_ready && (side_reg != 5'd0);
    assign deq          = !pipe_active && !fifo_empty;
    assign head_blocked = pipe_active && !fifo_empty;

    always_comb begin
        WB_RegWrite      = MEM_WB_RegWrite;
        WB_WriteRegister = MEM_WB_WriteRegister;
        WB_WriteData     = MEM_WB_WriteData;
        if (deq) begin
            WB_RegWrite      = 1'b1;
            WB_WriteRegister = reg_mem[rd_ptr_q];
            WB_WriteData     = data_mem[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (enq && !deq) begin
            count_d = count_q + CW'(1);
        end else if (!enq && deq) begin
            count_d = count_q - CW'(1);
        end
    end

    // Slot gi is live when its distance from the read pointer is below the count.
    logic [31:0] entry_onehot [DEPTH];
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_sb
            logic [PW-1:0] offs;
            assign offs = PW'(gi) - rd_ptr_q;
            assign entry_onehot[gi] = (CW'(offs) < count_q) ? (32'd1 << reg_mem[gi]) : 32'd0;
        end
    endgenerate

    always_comb begin
        pending_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_mask = pending_mask | entry_onehot[i];
        end
    end

    assign hazard_rs     = (query_rs != 5'd0) && pending_mask[query_rs];
    assign hazard_rt     = (query_rt != 5'd0) && pending_mask[query_rt];
    assign stall_req     = (state_q == ST_BUBBLE);
    assign collision_err = collision_q;

    always_ff @(posedge Clk) begin
        if (enq) begin
            reg_mem[wr_ptr_q]  <= side_reg;
            data_mem[wr_ptr_q] <= side_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            collision_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            collision_q <= collision_q | (pipe_active && pending_mask[MEM_WB_WriteRegister]);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            starve_q <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    starve_q <= 8'd0;
                    if (count_d != '0) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (deq) begin
                        starve_q <= 8'd0;
                        if (count_d == '0) begin
                            state_q <= ST_IDLE;
                        end
                    end else if (head_blocked) begin
                        if (starve_q == 8'(STARVE_LIMIT - 1)) begin
                            state_q <= ST_BUBBLE;
                        end else begin
                            starve_q <= starve_q + 8'd1;
                        end
                    end
                end
                ST_BUBBLE: begin
                    if (deq) begin
                        starve_q <= 8'd0;
                        state_q  <= (count_d == '0) ? ST_IDLE : ST_WAIT;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    starve_q <= 8'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: hand-computed expectations for writeback muxing,
// FIFO backpressure, starvation bubble, scoreboard hazards, collision flag and reset flush.
module tb_wb_port_arbiter;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_WriteRegister;
    logic [31:0] MEM_WB_WriteData;
    logic        side_valid;
    logic        side_ready;
    logic [4:0]  side_reg;
    logic [31:0] side_data;
    logic [4:0]  query_rs;
    logic [4:0]  query_rt;
    logic        WB_RegWrite;
    logic [4:0]  WB_WriteRegister;
    logic [31:0] WB_WriteData;
    logic [31:0] pending_mask;
    logic        hazard_rs;
    logic        hazard_rt;
    logic        stall_req;
    logic        collision_err;

    int n_vec = 0;
    int n_bad = 0;

    wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .Clk                  (Clk),
        .Reset                (Reset),
        .MEM_WB_RegWrite      (MEM_WB_RegWrite),
        .MEM_WB_WriteRegister (MEM_WB_WriteRegister),
        .MEM_WB_WriteData     (MEM_WB_WriteData),
        .side_valid           (side_valid),
        .side_ready           (side_ready),
        .side_reg             (side_reg),
        .side_data            (side_data),
        .query_rs             (query_rs),
        .query_rt             (query_rt),
        .WB_RegWrite          (WB_RegWrite),
        .WB_WriteRegister     (WB_WriteRegister),
        .WB_WriteData         (WB_WriteData),
        .pending_mask         (pending_mask),
        .hazard_rs            (hazard_rs),
        .hazard_rt            (hazard_rt),
        .stall_req            (stall_req),
        .collision_err        (collision_err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end else begin
            $display("vec %0d %s = %08h", n_vec, tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic pipe(input logic we, input logic [4:0] rd, input logic [31:0] wd);
        MEM_WB_RegWrite      = we;
        MEM_WB_WriteRegister = rd;
        MEM_WB_WriteData     = wd;
    endtask

    task automatic side(input logic v, input logic [4:0] rd, input logic [31:0] wd);
        side_valid = v;
        side_reg   = rd;
        side_data  = wd;
    endtask

    initial begin
        Reset    = 1'b1;
        query_rs = 5'd0;
        query_rt = 5'd0;
        pipe(1'b0, 5'd0, 32'd0);
        side(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        Reset = 1'b0;
        settle();
        check("rst_side_ready", 32'(side_ready), 32'd1);
        check("rst_pending", pending_mask, 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_collision", 32'(collision_err), 32'd0);
        check("rst_wb_we", 32'(WB_RegWrite), 32'd0);

        // Single side result, idle pipeline: written the cycle after acceptance.
        side(1'b1, 5'd5, 32'hDEADBEEF);
        settle();
        check("t1_ready", 32'(side_ready), 32'd1);
        check("t1_no_bypass", 32'(WB_RegWrite), 32'd0);
        tick();
        side(1'b0, 5'd0, 32'd0);
        settle();
        check("t1_wb_we", 32'(WB_RegWrite), 32'd1);
        check("t1_wb_reg", 32'(WB_WriteRegister), 32'd5);
        check("t1_wb_data", WB_WriteData, 32'hDEADBEEF);
        check("t1_pending", pending_mask, 32'h0000_0020);
        tick();
        check("t1_pending_clr", pending_mask, 32'd0);
        check("t1_wb_idle", 32'(WB_RegWrite), 32'd0);

        // Pipeline hogs the port while the side unit pushes regs 8..12.
        pipe(1'b1, 5'd3, 32'h11);
        for (int c = 0; c <= 9; c++) begin
            int k;
            k = (c < 4) ? 8 + c : 12;
            side(1'b1, 5'(k), 32'h100 + 32'(k));
            settle();
            $display("cycle %0d: side reg %0d ready=%0d stall=%0d", c, k, side_ready, stall_req);
            check($sformatf("t2_ready_c%0d", c), 32'(side_ready), (c < 4) ? 32'd1 : 32'd0);
            check($sformatf("t2_wb_reg_c%0d", c), 32'(WB_WriteRegister), 32'd3);
            check($sformatf("t2_stall_c%0d", c), 32'(stall_req), (c == 9) ? 32'd1 : 32'd0);
            if (c >= 4) begin
                check($sformatf("t2_pending_c%0d", c), pending_mask, 32'h0000_0F00);
            end
            if (c < 9) begin
                tick();
            end
        end

        // Release the pipeline: queued results drain in order, reg 12 slips in.
        pipe(1'b0, 5'd0, 32'd0);
        settle();
        check("t3_wb_we0", 32'(WB_RegWrite), 32'd1);
        check("t3_wb_reg0", 32'(WB_WriteRegister), 32'd8);
        check("t3_wb_data0", WB_WriteData, 32'h108);
        check("t3_ready0", 32'(side_ready), 32'd0);
        tick();
        check("t3_stall_clr", 32'(stall_req), 32'd0);
        check("t3_ready1", 32'(side_ready), 32'd1);
        check("t3_wb_reg1", 32'(WB_WriteRegister), 32'd9);
        tick();
        side(1'b0, 5'd0, 32'd0);
        settle();
        check("t3_wb_reg2", 32'(WB_WriteRegister), 32'd10);
        check("t3_pending2", pending_mask, 32'h0000_1C00);
        tick();
        check("t3_wb_reg3", 32'(WB_WriteRegister), 32'd11);
        tick();
        check("t3_wb_reg4", 32'(WB_WriteRegister), 32'd12);
        check("t3_wb_data4", WB_WriteData, 32'h10C);
        check("t3_pending4", pending_mask, 32'h0000_1000);
        tick();
        check("t3_drained_we", 32'(WB_RegWrite), 32'd0);
        check("t3_drained_pending", pending_mask, 32'd0);
        check("t3_drained_stall", 32'(stall_req), 32'd0);

        // Register 0 result is acknowledged and dropped.
        side(1'b1, 5'd0, 32'h1234);
        settle();
        check("t4_ready", 32'(side_ready), 32'd1);
        tick();
        side(1'b0, 5'd0, 32'd0);
        settle();
        check("t4_no_write", 32'(WB_RegWrite), 32'd0);
        check("t4_pending", pending_mask, 32'd0);

        // Queue reg 7 behind a busy pipeline, then probe hazards and collide.
        pipe(1'b1, 5'd4, 32'h44);
        side(1'b1, 5'd7, 32'h77);
        tick();
        side(1'b0, 5'd0, 32'd0);
        query_rs = 5'd7;
        query_rt = 5'd0;
        settle();
        check("t6_pending", pending_mask, 32'h0000_0080);
        check("t6_hazard_rs", 32'(hazard_rs), 32'd1);
        check("t6_hazard_rt", 32'(hazard_rt), 32'd0);
        check("t5_no_coll_yet", 32'(collision_err), 32'd0);
        pipe(1'b1, 5'd7, 32'h55);
        settle();
        check("t5_pipe_wins_reg", 32'(WB_WriteRegister), 32'd7);
        check("t5_pipe_wins_data", WB_WriteData, 32'h55);
        tick();
        check("t5_collision", 32'(collision_err), 32'd1);
        pipe(1'b0, 5'd0, 32'd0);
        settle();
        check("t6_drain_data", WB_WriteData, 32'h77);
        tick();
        check("t6_hazard_rs_clr", 32'(hazard_rs), 32'd0);
        check("t6_hazard_rt_clr", 32'(hazard_rt), 32'd0);
        check("t5_collision_sticky", 32'(collision_err), 32'd1);

        // Reset mid-drain flushes queued entries and clears the sticky flag.
        pipe(1'b1, 5'd4, 32'h44);
        side(1'b1, 5'd7, 32'h70);
        tick();
        side(1'b1, 5'd9, 32'h90);
        tick();
        side(1'b0, 5'd0, 32'd0);
        settle();
        check("t5_requeued", pending_mask, 32'h0000_0280);
        pipe(1'b0, 5'd0, 32'd0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        settle();
        check("t5_rst_pending", pending_mask, 32'd0);
        check("t5_rst_collision", 32'(collision_err), 32'd0);
        check("t5_rst_wb_we", 32'(WB_RegWrite), 32'd0);
        check("t5_rst_ready", 32'(side_ready), 32'd1);
        tick();
        check("t5_rst_no_late_write", 32'(WB_RegWrite), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
